// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a single
// global 2-bit saturating branch predictor.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [1:0]  CNT_INIT = 2'b10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        pc_write_i,
    input  logic        stall_i,
    input  logic        mem_stall_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        br_resolve_i,
    input  logic        br_taken_i,
    input  logic        br_pred_i,
    input  logic [31:0] br_redirect_pc_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_pred_o,
    output logic        ifid_valid_o
);

    logic [31:0] r_pc;
    logic [1:0]  r_cnt;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_pred;
    logic        r_ifid_valid;

    logic        w_is_br;
    logic [31:0] w_imm_b;
    logic [31:0] w_target;
    logic        w_pred;
    logic [31:0] w_next_seq;
    logic        w_mispredict;

    always_comb begin
        w_is_br      = (imem_data_i[6:0] == 7'b1100011);
        w_imm_b      = {{19{imem_data_i[31]}}, imem_data_i[31], imem_data_i[7],
                        imem_data_i[30:25], imem_data_i[11:8], 1'b0};
        w_target     = r_pc + w_imm_b;
        w_pred       = w_is_br && r_cnt[1];
        w_next_seq   = w_pred ? w_target : r_pc + 32'd4;
        w_mispredict = br_resolve_i && (br_taken_i != br_pred_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc         <= RESET_PC;
            r_cnt        <= CNT_INIT;
            r_ifid_pc    <= 32'd0;
            r_ifid_instr <= 32'd0;
            r_ifid_pred  <= 1'b0;
            r_ifid_valid <= 1'b0;
        end else if (!mem_stall_i) begin
            if (!start_i) begin
                r_ifid_pc    <= 32'd0;
                r_ifid_instr <= 32'd0;
                r_ifid_pred  <= 1'b0;
                r_ifid_valid <= 1'b0;
            end else begin
                // Training happens on every resolve, independent of the redirect.
                if (br_resolve_i) begin
                    if (br_taken_i) begin
                        if (r_cnt != 2'b11) r_cnt <= r_cnt + 2'd1;
                    end else begin
                        if (r_cnt != 2'b00) r_cnt <= r_cnt - 2'd1;
                    end
                end
                if (w_mispredict) begin
                    // Wrong-path instruction in IF/ID is dropped even if ID asked to hold it.
                    r_pc         <= br_redirect_pc_i;
                    r_ifid_pc    <= 32'd0;
                    r_ifid_instr <= 32'd0;
                    r_ifid_pred  <= 1'b0;
                    r_ifid_valid <= 1'b0;
                end else begin
                    if (pc_write_i) r_pc <= w_next_seq;
                    if (!stall_i) begin
                        r_ifid_pc    <= r_pc;
                        r_ifid_instr <= imem_data_i;
                        r_ifid_pred  <= w_pred;
                        r_ifid_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign imem_addr_o  = r_pc;
    assign ifid_pc_o    = r_ifid_pc;
    assign ifid_instr_o = r_ifid_instr;
    assign ifid_pred_o  = r_ifid_pred;
    assign ifid_valid_o = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; the predictor counter is
// observed through the prediction attached to a branch parked in IF.
module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] BEQ16 = 32'h0000_0863;
    localparam logic [31:0] BEQ8  = 32'h0000_0463;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, pc_write, stall, mem_stall;
    logic [31:0] imem_addr, imem_data;
    logic        br_resolve, br_taken, br_pred;
    logic [31:0] br_redirect;
    logic [31:0] ifid_pc, ifid_instr;
    logic        ifid_pred, ifid_valid;

    logic [31:0] mem [256];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[9:2]];

    fetch_stage dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .start_i          (start),
        .pc_write_i       (pc_write),
        .stall_i          (stall),
        .mem_stall_i      (mem_stall),
        .imem_addr_o      (imem_addr),
        .imem_data_i      (imem_data),
        .br_resolve_i     (br_resolve),
        .br_taken_i       (br_taken),
        .br_pred_i        (br_pred),
        .br_redirect_pc_i (br_redirect),
        .ifid_pc_o        (ifid_pc),
        .ifid_instr_o     (ifid_instr),
        .ifid_pred_o      (ifid_pred),
        .ifid_valid_o     (ifid_valid)
    );

    function automatic logic [97:0] obs();
        return {imem_addr, ifid_pc, ifid_instr, ifid_pred, ifid_valid};
    endfunction

    function automatic logic [97:0] ev(input logic [31:0] a, input logic [31:0] p,
                                       input logic [31:0] i, input logic pr, input logic v);
        return {a, p, i, pr, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic r, input logic t, input logic p, input logic [31:0] pc);
        br_resolve  = r;
        br_taken    = t;
        br_pred     = p;
        br_redirect = pc;
    endtask

    task automatic test_reset();
        logic [97:0] e;
        #12;
        e = ev(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL reset got=%h want=%h", obs(), e);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_linear();
        logic [97:0] e;
        start = 1'b1; pc_write = 1'b1; stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            e = ev(32'(4 * i), 32'(4 * (i - 1)), NOP, 1'b0, 1'b1);
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL linear[%0d] got=%h want=%h", i, obs(), e);
            end
        end
    endtask

    task automatic test_load_use();
        logic [97:0] exp_q [$];
        exp_q = '{ev(32'h10, 32'h0c, NOP, 1'b0, 1'b1), ev(32'h14, 32'h10, NOP, 1'b0, 1'b1),
                  ev(32'h18, 32'h14, NOP, 1'b0, 1'b1), ev(32'h18, 32'h18, NOP, 1'b0, 1'b1),
                  ev(32'h1c, 32'h18, NOP, 1'b0, 1'b1), ev(32'h20, 32'h1c, NOP, 1'b0, 1'b1)};
        for (int i = 0; i < 6; i++) begin
            // step 0: load-use hold; step 3: pc_write=0 with stall=0 replays the fetch
            pc_write = !(i == 0 || i == 3);
            stall    = (i == 0);
            tick();
            total++;
            if (obs() !== exp_q[i]) begin
                bad++;
                $display("FAIL load_use[%0d] got=%h want=%h", i, obs(), exp_q[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [97:0] e;
        pc_write = 1'b1; stall = 1'b0;
        tick();
        e = ev(32'h30, 32'h20, BEQ16, 1'b1, 1'b1);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL branch_pred got=%h want=%h", obs(), e);
        end
        resolve(1'b1, 1'b0, 1'b1, 32'h24);
        pc_write = 1'b0;
        tick();
        e = ev(32'h24, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL branch_flush got=%h want=%h", obs(), e);
        end
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        e = ev(32'h24, 32'h24, BEQ8, 1'b0, 1'b1);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL branch_cnt01 got=%h want=%h", obs(), e);
        end
    endtask

    task automatic test_mem_stall();
        logic [97:0] e;
        logic        pq [4];
        mem_stall = 1'b1; pc_write = 1'b1; stall = 1'b0;
        resolve(1'b1, 1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            e = ev(32'h24, 32'h24, BEQ8, 1'b0, 1'b1);
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL mem_stall[%0d] got=%h want=%h", i, obs(), e);
            end
        end
        mem_stall = 1'b0; pc_write = 1'b0;
        // counter 01 -> 10 (single update), then a not-taken takes it back to 01
        pq = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      resolve(1'b1, 1'b1, 1'b1, 32'h0);
            else if (i == 2) resolve(1'b1, 1'b0, 1'b0, 32'h0);
            else             resolve(1'b0, 1'b0, 1'b0, 32'h0);
            tick();
            e = ev(32'h24, 32'h24, BEQ8, pq[i], 1'b1);
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL post_stall[%0d] got=%h want=%h", i, obs(), e);
            end
        end
    endtask

    task automatic test_flush_priority();
        logic [97:0] e;
        stall = 1'b1; pc_write = 1'b0;
        resolve(1'b1, 1'b1, 1'b0, 32'h40);
        tick();
        e = ev(32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL flush_wins got=%h want=%h", obs(), e);
        end
        stall = 1'b0;
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        e = ev(32'h40, 32'h40, BEQ8, 1'b1, 1'b1);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL flush_after got=%h want=%h", obs(), e);
        end
    endtask

    task automatic test_saturate();
        logic [97:0] e;
        logic        pq [12];
        // counter starts at 10: 4 taken, idle, 5 not-taken, idle, taken
        pq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        pc_write = 1'b0; stall = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 4)                resolve(1'b1, 1'b1, 1'b1, 32'h0);
            else if (i >= 5 && i < 10) resolve(1'b1, 1'b0, 1'b0, 32'h0);
            else if (i == 11)         resolve(1'b1, 1'b1, 1'b1, 32'h0);
            else                      resolve(1'b0, 1'b0, 1'b0, 32'h0);
            tick();
            e = ev(32'h40, 32'h40, BEQ8, pq[i], 1'b1);
            total++;
            if (obs() !== e) begin
                bad++;
                $display("FAIL saturate[%0d] got=%h want=%h", i, obs(), e);
            end
        end
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid();
        logic [97:0] e;
        pc_write = 1'b1;
        tick();
        // counter is 01, so the branch at 0x40 falls through
        e = ev(32'h44, 32'h40, BEQ8, 1'b0, 1'b1);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL pre_reset got=%h want=%h", obs(), e);
        end
        #2 rst_n = 1'b0;
        #1;
        e = ev(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (obs() !== e) begin
            bad++;
            $display("FAIL reset_mid got=%h want=%h", obs(), e);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_start_gate();
        logic [97:0] exp_q [$];
        exp_q = '{ev(32'h4, 32'h0, NOP, 1'b0, 1'b1), ev(32'h4, 32'h0, 32'h0, 1'b0, 1'b0),
                  ev(32'h8, 32'h4, NOP, 1'b0, 1'b1)};
        pc_write = 1'b1; stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = (i != 1);
            // a would-be mispredict while stopped must not redirect
            if (i == 1) resolve(1'b1, 1'b0, 1'b1, 32'h80);
            else        resolve(1'b0, 1'b0, 1'b0, 32'h0);
            tick();
            total++;
            if (obs() !== exp_q[i]) begin
                bad++;
                $display("FAIL start_gate[%0d] got=%h want=%h", i, obs(), exp_q[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        mem[8]  = BEQ16;
        mem[9]  = BEQ8;
        mem[16] = BEQ8;
        rst_n = 1'b0; start = 1'b0; pc_write = 1'b0; stall = 1'b0; mem_stall = 1'b0;
        resolve(1'b0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_linear();
        test_load_use();
        test_branch();
        test_mem_stall();
        test_flush_priority();
        test_saturate();
        test_reset_mid();
        test_start_gate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
